// File: rtl/logic_pkg.sv
// Shared types for the logic-unit result path: op encoding and result record.
package logic_pkg;

  localparam int LOGIC_W = 8;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } logic_op_t;

  typedef struct packed {
    logic [LOGIC_W-1:0] d;
    logic_op_t          op;
    logic               zero;
    logic               parity;
  } logic_res_t;

endpackage

// File: rtl/lrf_flag_gen.sv
// Zero and parity flag generation for one logic-unit result word.
module lrf_flag_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d_i,
  output logic             zero_o,
  output logic             parity_o
);

  assign zero_o   = ~|d_i;
  assign parity_o = ^d_i;

endmodule

// File: rtl/logic_result_fifo.sv
// Result FIFO behind the 8-bit logic unit. Stores each result with its op
// select and precomputed zero/parity flags, and hands entries to the consumer
// over valid/ready.
// Build option LRF_BYPASS_EN: when the FIFO is empty an incoming result is
// presented combinationally and, if accepted the same cycle, never stored.
module logic_result_fifo
  import logic_pkg::*;
#(
  parameter int WIDTH = LOGIC_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_d,
  input  logic [1:0]             in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_d,
  output logic [1:0]             out_op,
  output logic                   out_zero,
  output logic                   out_parity,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_d_q   [DEPTH];
  logic_op_t        mem_op_q  [DEPTH];
  logic             mem_zero_q[DEPTH];
  logic             mem_par_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic in_zero, in_par;
  logic fifo_valid;
  logic byp_take;
  logic push, pop;

  lrf_flag_gen #(.WIDTH(WIDTH)) u_flag_in (
    .d_i      (in_d),
    .zero_o   (in_zero),
    .parity_o (in_par)
  );

  // Full blocks input regardless of a same-cycle pop, so out_ready never
  // reaches in_ready.
  assign in_ready   = (count_q < FULL_CNT);
  assign fifo_valid = (count_q != '0);
  assign count      = count_q;

`ifdef LRF_BYPASS_EN
  logic byp_act;
  logic byp_zero, byp_par;

  lrf_flag_gen #(.WIDTH(WIDTH)) u_flag_byp (
    .d_i      (in_d),
    .zero_o   (byp_zero),
    .parity_o (byp_par)
  );

  assign byp_act  = (count_q == '0) & in_valid;
  assign byp_take = byp_act & out_ready;

  // Empty FIFO shows the live input; otherwise the stored head.
  always_comb begin
    out_valid  = fifo_valid | byp_act;
    out_d      = mem_d_q[rd_ptr_q];
    out_op     = mem_op_q[rd_ptr_q];
    out_zero   = mem_zero_q[rd_ptr_q];
    out_parity = mem_par_q[rd_ptr_q];
    if (byp_act) begin
      out_d      = in_d;
      out_op     = in_op;
      out_zero   = byp_zero;
      out_parity = byp_par;
    end
  end
`else
  assign byp_take   = 1'b0;
  assign out_valid  = fifo_valid;
  assign out_d      = mem_d_q[rd_ptr_q];
  assign out_op     = mem_op_q[rd_ptr_q];
  assign out_zero   = mem_zero_q[rd_ptr_q];
  assign out_parity = mem_par_q[rd_ptr_q];
`endif

  // A bypassed-and-consumed result is neither stored nor popped.
  assign push = in_valid & in_ready & ~byp_take;
  assign pop  = fifo_valid & out_ready;

  // Next-state for pointers and occupancy; pointers wrap naturally mod DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the idle head reads as a zero result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d_q[i]    <= '0;
        mem_op_q[i]   <= OP_AND;
        mem_zero_q[i] <= 1'b1;
        mem_par_q[i]  <= 1'b0;
      end
    end else if (push) begin
      mem_d_q[wr_ptr_q]    <= in_d;
      mem_op_q[wr_ptr_q]   <= logic_op_t'(in_op);
      mem_zero_q[wr_ptr_q] <= in_zero;
      mem_par_q[wr_ptr_q]  <= in_par;
    end
  end

endmodule

// File: tb/tb_logic_result_fifo.sv
// Directed self-checking bench for logic_result_fifo (WIDTH=8, DEPTH=4).
module tb_logic_result_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_d;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_d;
  logic [1:0] out_op;
  logic       out_zero;
  logic       out_parity;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] fill_d [4];
  logic [1:0] fill_op[4];
  logic       fill_p [4];

  logic_result_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_d       (in_d),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_d      (out_d),
    .out_op     (out_op),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] op);
    in_valid = 1'b1;
    in_d     = d;
    in_op    = op;
    cyc();
    in_valid = 1'b0;
    in_d     = 8'hEE;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    fill_d[0] = 8'hA5; fill_op[0] = 2'b01; fill_p[0] = 1'b0;
    fill_d[1] = 8'hFF; fill_op[1] = 2'b10; fill_p[1] = 1'b0;
    fill_d[2] = 8'h01; fill_op[2] = 2'b11; fill_p[2] = 1'b1;
    fill_d[3] = 8'h80; fill_op[3] = 2'b00; fill_p[3] = 1'b1;

    rst = 1'b1; in_valid = 1'b0; in_d = '0; in_op = '0; out_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // reset state
    chk("rst_count",  count,      0);
    chk("rst_valid",  out_valid,  0);
    chk("rst_ready",  in_ready,   1);
    chk("rst_d",      out_d,      0);
    chk("rst_zero",   out_zero,   1);
    chk("rst_parity", out_parity, 0);

    // single push of a zero result
    push(8'h00, 2'b00);
    chk("one_valid",  out_valid,  1);
    chk("one_d",      out_d,      8'h00);
    chk("one_zero",   out_zero,   1);
    chk("one_parity", out_parity, 0);
    chk("one_op",     out_op,     2'b00);
    chk("one_count",  count,      1);
    pop();
    chk("one_empty_count", count,     0);
    chk("one_empty_valid", out_valid, 0);

    // fill to full, overflow push ignored, then drain
    for (int i = 0; i < 4; i++) push(fill_d[i], fill_op[i]);
    chk("full_count", count,    4);
    chk("full_ready", in_ready, 0);
    in_valid = 1'b1; in_d = 8'h7E; in_op = 2'b10; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("full_poppush_count", count, 3);
    chk("full_poppush_head",  out_d, fill_d[1]);
    for (int i = 1; i < 4; i++) begin
      chk("drain_d",      out_d,      fill_d[i]);
      chk("drain_op",     out_op,     fill_op[i]);
      chk("drain_parity", out_parity, fill_p[i]);
      chk("drain_zero",   out_zero,   0);
      pop();
    end
    chk("drain_count", count,     0);
    chk("drain_valid", out_valid, 0);

    // pure overflow: full FIFO, push of 7E with no pop changes nothing
    for (int i = 0; i < 4; i++) push(fill_d[i], fill_op[i]);
    push(8'h7E, 2'b01);
    chk("ovf_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_d", out_d, fill_d[i]);
      chk("ovf_parity", out_parity, fill_p[i]);
      pop();
    end
    chk("ovf_empty", count, 0);

    // streaming at count=2: push and pop every cycle
    push(8'h00, 2'b00);
    push(8'h01, 2'b01);
    for (int k = 0; k < 10; k++) begin
      chk("stream_d",     out_d, 8'(k));
      chk("stream_count", count, 2);
      in_valid = 1'b1; in_d = 8'(k + 2); in_op = 2'(k); out_ready = 1'b1;
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_end_count", count, 2);
    chk("stream_tail0", out_d, 8'h0A);
    pop();
    chk("stream_tail1", out_d, 8'h0B);
    chk("stream_tail1_op", out_op, 2'b01);
    pop();
    chk("stream_empty", count, 0);

    // back-pressure holds the head
    push(8'h3C, 2'b10);
    for (int k = 0; k < 5; k++) begin
      chk("bp_d",     out_d,     8'h3C);
      chk("bp_valid", out_valid, 1);
      cyc();
    end
    pop();
    chk("bp_pop_count", count,     0);
    chk("bp_pop_valid", out_valid, 0);

    // reset mid-stream with three entries held
    push(8'h11, 2'b01);
    push(8'h22, 2'b10);
    push(8'h33, 2'b11);
    chk("mid_count", count, 3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_count", count,     0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_zero",  out_zero,  1);
    cyc();
    rst = 1'b0;
    push(8'h5A, 2'b10);
    chk("after_rst_d",     out_d,      8'h5A);
    chk("after_rst_count", count,      1);
    chk("after_rst_par",   out_parity, 0);
    pop();
    chk("after_rst_empty", count, 0);

`ifdef LRF_BYPASS_EN
    // zero-latency bypass on an empty FIFO
    in_valid = 1'b1; in_d = 8'h81; in_op = 2'b01; out_ready = 1'b1;
    #1;
    chk("byp_valid",  out_valid,  1);
    chk("byp_d",      out_d,      8'h81);
    chk("byp_parity", out_parity, 0);
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("byp_count", count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
